instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory address width; maximum program length 2^ADDR_W words.
REQ-002 SHALL have port Clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port Resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a load; sampled only in IDLE, RUN or ERR.
REQ-005 SHALL have port in_data  input  8  serial program byte.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port mem_addr  output  ADDR_W  write address.
REQ-010 SHALL have port mem_wdata  output  16  write data.
REQ-011 SHALL have port cpu_run  output  1  CPU release; low holds the downstream 16-bit CPU in reset.
REQ-012 SHALL have port err  output  1  load aborted on an illegal word count.

Function
REQ-013 SHALL implement states IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, RUN, ERR.
REQ-014 A byte SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; in_ready SHALL be 1 exactly in CNT_HI, CNT_LO, DAT_HI and DAT_LO.
REQ-015 Stream format SHALL be: count high byte, count low byte, then count words, each sent high byte first.
REQ-016 On start=1 in IDLE, RUN or ERR: next state CNT_HI; word counter and address cleared; cpu_run and err cleared on the same edge.
REQ-017 start SHALL be ignored in CNT_HI, CNT_LO, DAT_HI, DAT_LO and WRITE.
REQ-018 CNT_HI -> CNT_LO, and CNT_LO -> (check), each on an accepted byte; the 16-bit count is registered.
REQ-019 After CNT_LO: count 0 or count > 2^ADDR_W -> ERR; otherwise -> DAT_HI.
REQ-020 DAT_HI -> DAT_LO on an accepted byte; DAT_LO -> WRITE on an accepted byte.
REQ-021 In WRITE (one cycle): mem_we=1, mem_wdata = {high byte, low byte}, mem_addr = current word index.
REQ-022 The word index SHALL increment after each WRITE; WRITE -> DAT_HI if words remain, else -> RUN.
REQ-023 Write latency: mem_we is asserted in the cycle immediately after the low-byte acceptance.
REQ-024 Address SHALL run 0 .. count-1 and never wrap; a count of exactly 2^ADDR_W ends at address 2^ADDR_W-1.
REQ-025 mem_we SHALL be 0 in every state except WRITE; mem_addr and mem_wdata hold their last values when mem_we=0.
REQ-026 RUN: cpu_run=1, held until reset or start.
REQ-027 ERR: err=1 and cpu_run=0, held until reset or start.
REQ-028 in_valid while in_ready=0 SHALL be ignored; the byte is neither consumed nor stored.

Reset
REQ-029 Resetn=0 SHALL asynchronously force IDLE, with in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, err=0, and counters=0.
REQ-030 Reset asserted mid-load SHALL abort the load immediately; no further writes occur, and the words already written stay in memory.
REQ-031 After reset release the block SHALL stay in IDLE until start.

Verification
REQ-032 Send start, then bytes 00 02 12 34 AB CD -> mem_we pulses at addr 0 with data 0x1234 and at addr 1 with data 0xABCD; cpu_run=1 on the cycle after the second WRITE.
REQ-033 Send start, then count bytes 00 00 -> err=1, cpu_run=0, and no mem_we pulse.
REQ-034 Send start, then count bytes 01 01 (257) with ADDR_W=8 -> err=1; count 01 00 (256) -> 256 writes at addr 0..255, then cpu_run=1.
REQ-035 Hold in_valid low for 5 cycles between the high and low data bytes -> state holds in DAT_LO, and the word is written correctly once the low byte arrives.
REQ-036 Assert Resetn=0 after 1 of 3 words is written -> all outputs 0 without waiting for a clock edge; a new start reloads cleanly from addr 0.
REQ-037 Assert start while in DAT_HI -> ignored, and the load completes unaffected.

Source files
------------

// File: rtl/instr_loader.sv
// Serial program loader: receives a 16-bit word count followed by that many
// 16-bit words (high byte first), writes them to instruction memory at
// consecutive addresses, then releases the downstream CPU from reset.
module instr_loader #(
  parameter int unsigned ADDR_W = 8  // supported range 1..16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_run,
  output logic              err
);

  typedef enum logic [2:0] {
    StIdle,
    StCntHi,
    StCntLo,
    StDatHi,
    StDatLo,
    StWrite,
    StRun,
    StErr
  } state_e;

  // Largest legal count is 2^ADDR_W, so compare in 17 bits.
  localparam logic [16:0] MaxCount = 17'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [ADDR_W:0]   widx_q, widx_d;
  logic [7:0]        hi_q, hi_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_run_q, cpu_run_d;
  logic              err_q, err_d;

  logic        accept;
  logic [15:0] count_full;
  logic        last_word;

  assign accept     = in_valid & in_ready_q;
  assign count_full = {count_q[15:8], in_data};
  // Word index is one wider than the address so a full 2^ADDR_W load never wraps.
  assign last_word  = (17'(widx_q) + 17'd1) == 17'(count_q);

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    widx_d      = widx_q;
    hi_d        = hi_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      StIdle, StRun, StErr: begin
        if (start) begin
          state_d    = StCntHi;
          widx_d     = '0;
          mem_addr_d = '0;
        end
      end
      StCntHi: begin
        if (accept) begin
          count_d[15:8] = in_data;
          state_d       = StCntLo;
        end
      end
      StCntLo: begin
        if (accept) begin
          count_d = count_full;
          if (count_full == 16'd0 || 17'(count_full) > MaxCount) begin
            state_d = StErr;
          end else begin
            state_d = StDatHi;
          end
        end
      end
      StDatHi: begin
        if (accept) begin
          hi_d    = in_data;
          state_d = StDatLo;
        end
      end
      StDatLo: begin
        if (accept) begin
          mem_wdata_d = {hi_q, in_data};
          mem_addr_d  = widx_q[ADDR_W-1:0];
          state_d     = StWrite;
        end
      end
      StWrite: begin
        widx_d  = widx_q + 1'b1;
        state_d = last_word ? StRun : StDatHi;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they change on the same edge.
    in_ready_d = (state_d == StCntHi) || (state_d == StCntLo) ||
                 (state_d == StDatHi) || (state_d == StDatLo);
    mem_we_d   = (state_d == StWrite);
    cpu_run_d  = (state_d == StRun);
    err_d      = (state_d == StErr);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= StIdle;
      count_q     <= '0;
      widx_q      <= '0;
      hi_q        <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_run_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      widx_q      <= widx_d;
      hi_q        <= hi_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_run_q   <= cpu_run_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_run   = cpu_run_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed loads, a write scoreboard checked every
// clock, and literal expectations for the key scenarios.
module tb_instr_loader;

  localparam int unsigned AW = 8;

  logic          Clock = 1'b0;
  logic          Resetn;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          cpu_run;
  logic          err;

  instr_loader #(.ADDR_W(AW)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_run  (cpu_run),
    .err      (err)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  int   n_pass  = 0;
  int   n_total = 0;
  wr_t  exp_q[$];   // writes the program should still produce, in order
  wr_t  log_q[$];   // writes observed on the memory port
  wr_t  cur_e;
  logic we_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
  endtask

  // Every write strobe must match the next expected write and last one cycle.
  always @(negedge Clock) begin
    if (mem_we === 1'b1) begin
      log_q.push_back({mem_addr, mem_wdata});
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL spurious_we: addr 0x%0h data 0x%0h with no write pending",
                 mem_addr, mem_wdata);
      end else begin
        cur_e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(cur_e.addr));
        check("wr_data", 32'(mem_wdata), 32'(cur_e.data));
        check("wr_ready_low", 32'(in_ready), 32'd0);
      end
      check("we_one_cycle", 32'(we_prev), 32'd0);
    end
    we_prev <= mem_we;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // All driver tasks leave time at 1 unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n        = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    if (in_ready !== 1'b1) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    tick(1);
    in_valid = 1'b0;
  endtask

  // Write must appear in the cycle right after the low byte is accepted.
  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    check("we_latency", 32'(mem_we), 32'd1);
    check("wdata_now", 32'(mem_wdata), 32'(w));
  endtask

  function automatic logic [15:0] word_of(input int i);
    return 16'((i * 40503 + 17) ^ 16'hA5C3);
  endfunction

  task automatic load(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({AW'(i), word_of(i)});
    send_byte(8'(n >> 8));
    send_byte(8'(n));
    for (int i = 0; i < n; i++) send_word(word_of(i));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    Resetn   = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    check_all_zero("reset");
    @(negedge Clock);
    Resetn = 1'b1;
    // Stays idle without start; bytes offered while not ready are ignored.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick(3);
    in_valid = 1'b0;
    check("idle_ready", 32'(in_ready), 32'd0);
    check("idle_run", 32'(cpu_run), 32'd0);

    // Two-word program 00 02 12 34 AB CD.
    log_q.delete();
    do_start();
    check("start_ready", 32'(in_ready), 32'd1);
    exp_q.push_back({AW'(0), 16'h1234});
    exp_q.push_back({AW'(1), 16'hABCD});
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(16'h1234);
    check("run_not_early", 32'(cpu_run), 32'd0);
    send_word(16'hABCD);
    tick(1);
    check("t1_cpu_run", 32'(cpu_run), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    check("t1_nwrites", 32'(log_q.size()), 32'd2);
    check("t1_w0", 32'(log_q[0]), {8'h0, AW'(0), 16'h1234});
    check("t1_w1", 32'(log_q[1]), {8'h0, AW'(1), 16'hABCD});
    // Bytes offered in RUN are ignored.
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick(3);
    in_valid = 1'b0;
    check("run_hold", 32'(cpu_run), 32'd1);

    // Count 0 -> error, no writes.
    log_q.delete();
    do_start();
    check("t2_run_cleared", 32'(cpu_run), 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    check("t2_err", 32'(err), 32'd1);
    check("t2_cpu_run", 32'(cpu_run), 32'd0);
    check("t2_ready", 32'(in_ready), 32'd0);
    tick(3);
    check("t2_err_hold", 32'(err), 32'd1);
    check("t2_nwrites", 32'(log_q.size()), 32'd0);

    // Count 257 -> error.
    do_start();
    check("t3_err_cleared", 32'(err), 32'd0);
    send_byte(8'h01);
    send_byte(8'h01);
    check("t3_err", 32'(err), 32'd1);

    // Count 256 -> full address range, no wrap.
    log_q.delete();
    do_start();
    load(256);
    tick(1);
    check("t4_cpu_run", 32'(cpu_run), 32'd1);
    check("t4_err", 32'(err), 32'd0);
    check("t4_nwrites", 32'(log_q.size()), 32'd256);
    check("t4_first_addr", 32'(log_q[0].addr), 32'd0);
    check("t4_last_addr", 32'(log_q[255].addr), 32'd255);
    check("t4_pending", 32'(exp_q.size()), 32'd0);

    // Stall between high and low data bytes.
    log_q.delete();
    do_start();
    exp_q.push_back({AW'(0), 16'hC0DE});
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hC0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("t5_stall_ready", 32'(in_ready), 32'd1);
      check("t5_stall_we", 32'(mem_we), 32'd0);
    end
    send_byte(8'hDE);
    check("t5_we", 32'(mem_we), 32'd1);
    check("t5_data", 32'(mem_wdata), 32'hC0DE);
    tick(1);
    check("t5_cpu_run", 32'(cpu_run), 32'd1);

    // Reset mid-load after the first of three words.
    log_q.delete();
    do_start();
    for (int i = 0; i < 3; i++) exp_q.push_back({AW'(i), word_of(i)});
    send_byte(8'h00);
    send_byte(8'h03);
    send_word(word_of(0));
    send_byte(word_of(1) >> 8);
    #2;
    Resetn = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    tick(2);
    check("t6_nwrites", 32'(log_q.size()), 32'd1);
    @(negedge Clock);
    Resetn = 1'b1;
    tick(2);
    check("t6_idle_ready", 32'(in_ready), 32'd0);
    log_q.delete();
    do_start();
    load(2);
    tick(1);
    check("t6_cpu_run", 32'(cpu_run), 32'd1);
    check("t6_first_addr", 32'(log_q[0].addr), 32'd0);
    check("t6_nwrites2", 32'(log_q.size()), 32'd2);

    // Start during DAT_HI is ignored.
    log_q.delete();
    do_start();
    for (int i = 0; i < 3; i++) exp_q.push_back({AW'(i), word_of(i)});
    send_byte(8'h00);
    send_byte(8'h03);
    send_word(word_of(0));
    tick(1);
    do_start();
    check("t7_ready", 32'(in_ready), 32'd1);
    send_word(word_of(1));
    send_word(word_of(2));
    tick(1);
    check("t7_cpu_run", 32'(cpu_run), 32'd1);
    check("t7_nwrites", 32'(log_q.size()), 32'd3);
    check("t7_last_addr", 32'(log_q[2].addr), 32'd2);
    check("final_pending", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
